// File: rtl/ysyx_25020047_pkg.sv
// Shared types and constants for the ysyx_25020047 multi-cycle control sequencer.
package ysyx_25020047_pkg;

    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_FETCH = 3'd1,
        S_IWAIT = 3'd2,
        S_EXEC  = 3'd3,
        S_MEM   = 3'd4,
        S_MWAIT = 3'd5,
        S_WB    = 3'd6,
        S_HALT  = 3'd7
    } seq_state_e;

    localparam logic [1:0] HALT_EBREAK   = 2'd0;
    localparam logic [1:0] HALT_IFERR    = 2'd1;
    localparam logic [1:0] HALT_LSERR    = 2'd2;
    localparam logic [1:0] HALT_MISALIGN = 2'd3;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/ysyx_25020047_perf_cnt.sv
// Free-running 64-bit performance counters for the sequencer (cycles, retired
// instructions, memory stall cycles); instantiated only with YSYX_25020047_PERF_EN.
module ysyx_25020047_perf_cnt
    import ysyx_25020047_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cycle_en_i,
    input  logic        retire_en_i,
    input  logic        stall_en_i,
    output logic [63:0] cycle_cnt_o,
    output logic [63:0] instret_cnt_o,
    output logic [63:0] mem_stall_cnt_o
);

    logic [63:0] cycle_q, cycle_d;
    logic [63:0] instret_q, instret_d;
    logic [63:0] stall_q, stall_d;

    always_comb begin
        cycle_d   = cycle_en_i  ? cycle_q + 64'd1   : cycle_q;
        instret_d = retire_en_i ? instret_q + 64'd1 : instret_q;
        stall_d   = stall_en_i  ? stall_q + 64'd1   : stall_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q   <= '0;
            instret_q <= '0;
            stall_q   <= '0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
            stall_q   <= stall_d;
        end
    end

    assign cycle_cnt_o     = cycle_q;
    assign instret_cnt_o   = instret_q;
    assign mem_stall_cnt_o = stall_q;

endmodule

// File: rtl/ysyx_25020047_seq.sv
// Multi-cycle control sequencer: FETCH/IWAIT/EXEC/[MEM/MWAIT]/WB per instruction,
// owns the PC and commit strobes. Define YSYX_25020047_PERF_EN to add perf counters.
module ysyx_25020047_seq
    import ysyx_25020047_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ifu_req_valid,
    input  logic        ifu_req_ready,
    input  logic        ifu_rsp_valid,
    input  logic        ifu_rsp_err,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        is_ebreak,
    input  logic        rd_wen_dec,
    input  logic        csr_wen_dec,
    output logic        lsu_req_valid,
    input  logic        lsu_req_ready,
    input  logic        lsu_rsp_valid,
    input  logic        lsu_rsp_err,
    input  logic [31:0] dnpc,
    output logic [31:0] pc,
    output logic        inst_latch,
    output logic        rf_wen,
    output logic        csr_wen,
    output logic        retire,
    output logic        halted,
    output logic [1:0]  halt_code
`ifdef YSYX_25020047_PERF_EN
    ,
    output logic [63:0] cycle_cnt,
    output logic [63:0] instret_cnt,
    output logic [63:0] mem_stall_cnt
`endif
);

    seq_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  halt_code_q, halt_code_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RESET;
            pc_q        <= RESET_PC;
            halt_code_q <= HALT_EBREAK;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            halt_code_q <= halt_code_d;
        end
    end

    // Responses only matter in the wait states, so stray pulses elsewhere fall through.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        halt_code_d   = halt_code_q;
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        inst_latch    = 1'b0;
        rf_wen        = 1'b0;
        csr_wen       = 1'b0;
        retire        = 1'b0;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                ifu_req_valid = 1'b1;
                if (ifu_req_ready) state_d = S_IWAIT;
            end
            S_IWAIT: begin
                if (ifu_rsp_valid) begin
                    if (ifu_rsp_err) begin
                        state_d     = S_HALT;
                        halt_code_d = HALT_IFERR;
                    end else begin
                        inst_latch = 1'b1;
                        state_d    = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (is_ebreak) begin
                    state_d     = S_HALT;
                    halt_code_d = HALT_EBREAK;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                lsu_req_valid = 1'b1;
                if (lsu_req_ready) state_d = S_MWAIT;
            end
            S_MWAIT: begin
                if (lsu_rsp_valid) begin
                    if (lsu_rsp_err) begin
                        state_d     = S_HALT;
                        halt_code_d = HALT_LSERR;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            // A misaligned target suppresses the whole commit, leaving pc at the faulting instruction.
            S_WB: begin
                if (dnpc[1:0] != 2'b00) begin
                    state_d     = S_HALT;
                    halt_code_d = HALT_MISALIGN;
                end else begin
                    rf_wen  = rd_wen_dec & ~is_store;
                    csr_wen = csr_wen_dec;
                    retire  = 1'b1;
                    pc_d    = dnpc;
                    state_d = S_FETCH;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    assign pc        = pc_q;
    assign halted    = (state_q == S_HALT);
    assign halt_code = halt_code_q;

`ifdef YSYX_25020047_PERF_EN
    ysyx_25020047_perf_cnt u_perf_cnt (
        .clk             (clk),
        .rst_n           (rst_n),
        .cycle_en_i      (state_q != S_HALT),
        .retire_en_i     (retire),
        .stall_en_i      ((state_q == S_MEM) || (state_q == S_MWAIT)),
        .cycle_cnt_o     (cycle_cnt),
        .instret_cnt_o   (instret_cnt),
        .mem_stall_cnt_o (mem_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_ysyx_25020047_seq.sv
// Scoreboard bench for ysyx_25020047_seq: a reactive bus driver issues instructions and
// pushes expected commits; an independent monitor pops and compares on each commit/halt.
module tb_ysyx_25020047_seq;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_EBREAK = 3, K_IFERR = 4, K_LSERR = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ifu_req_valid, ifu_req_ready = 1'b0, ifu_rsp_valid = 1'b0, ifu_rsp_err = 1'b0;
    logic        is_load = 1'b0, is_store = 1'b0, is_ebreak = 1'b0;
    logic        rd_wen_dec = 1'b0, csr_wen_dec = 1'b0;
    logic        lsu_req_valid, lsu_req_ready = 1'b0, lsu_rsp_valid = 1'b0, lsu_rsp_err = 1'b0;
    logic [31:0] dnpc = 32'h0;
    logic [31:0] pc;
    logic        inst_latch, rf_wen, csr_wen, retire, halted;
    logic [1:0]  halt_code;
`ifdef YSYX_25020047_PERF_EN
    logic [63:0] cycle_cnt, instret_cnt, mem_stall_cnt;
`endif

    always #5 clk = ~clk;

    ysyx_25020047_seq #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_err   (ifu_rsp_err),
        .is_load       (is_load),
        .is_store      (is_store),
        .is_ebreak     (is_ebreak),
        .rd_wen_dec    (rd_wen_dec),
        .csr_wen_dec   (csr_wen_dec),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_err   (lsu_rsp_err),
        .dnpc          (dnpc),
        .pc            (pc),
        .inst_latch    (inst_latch),
        .rf_wen        (rf_wen),
        .csr_wen       (csr_wen),
        .retire        (retire),
        .halted        (halted),
        .halt_code     (halt_code)
`ifdef YSYX_25020047_PERF_EN
        ,
        .cycle_cnt     (cycle_cnt),
        .instret_cnt   (instret_cnt),
        .mem_stall_cnt (mem_stall_cnt)
`endif
    );

    typedef struct packed {
        logic [31:0] pc;
        logic        rf;
        logic        csr;
        logic        ret;
        logic        halt;
        logic [1:0]  code;
    } exp_t;

    exp_t        expQ[$];
    int          testsRun = 0;
    int          testsFailed = 0;
    logic [31:0] modelPc = RST_PC;
    int          lat = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        testsRun++;
        if (actual !== required) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        lat++;
    endtask

    task automatic clearInputs();
        ifu_req_ready = 0; ifu_rsp_valid = 0; ifu_rsp_err = 0;
        lsu_req_ready = 0; lsu_rsp_valid = 0; lsu_rsp_err = 0;
        is_load = 0; is_store = 0; is_ebreak = 0; rd_wen_dec = 0; csr_wen_dec = 0; dnpc = 32'h0;
    endtask

    // Reset values are checked while rst_n is still low.
    task automatic doReset();
        @(negedge clk);
        rst_n = 0;
        clearInputs();
        expQ.delete();
        repeat (2) @(negedge clk);
        checkOutput("reset pc", pc, RST_PC);
        checkOutput("reset halted", halted, 0);
        checkOutput("reset halt_code", halt_code, 0);
        checkOutput("reset req valids", {ifu_req_valid, lsu_req_valid}, 0);
        checkOutput("reset strobes", {inst_latch, rf_wen, csr_wen, retire}, 0);
`ifdef YSYX_25020047_PERF_EN
        checkOutput("reset counters", cycle_cnt | instret_cnt | mem_stall_cnt, 0);
`endif
        rst_n = 1;
        modelPc = RST_PC;
    endtask

    // One request/response handshake on the IFU (isLsu=0) or LSU (isLsu=1) side.
    task automatic busXfer(input bit isLsu, input int rdyDly, input int rspDly, input bit err,
                           input bit spur, input logic [31:0] expPc, output bit ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (isLsu ? lsu_req_valid : ifu_req_valid) break;
            tick();
        end
        if (!(isLsu ? lsu_req_valid : ifu_req_valid)) begin
            checkOutput(isLsu ? "lsu req timeout" : "ifu req timeout", 0, 1);
            return;
        end
        if (!isLsu) begin
            lat = 1;
            checkOutput("fetch pc", pc, expPc);
        end
        for (int i = 0; i < rdyDly; i++) begin
            tick();
            checkOutput(isLsu ? "lsu valid hold" : "ifu valid hold", isLsu ? lsu_req_valid : ifu_req_valid, 1);
        end
        if (isLsu) begin lsu_req_ready = 1; lsu_rsp_valid = spur; end
        else begin ifu_req_ready = 1; ifu_rsp_valid = spur; end
        tick();
        lsu_req_ready = 0; lsu_rsp_valid = 0; ifu_req_ready = 0; ifu_rsp_valid = 0;
        checkOutput(isLsu ? "lsu valid after accept" : "ifu valid after accept", isLsu ? lsu_req_valid : ifu_req_valid, 0);
        for (int i = 0; i < rspDly; i++) tick();
        if (isLsu) begin lsu_rsp_valid = 1; lsu_rsp_err = err; end
        else begin ifu_rsp_valid = 1; ifu_rsp_err = err; end
        #1;
        if (!isLsu) checkOutput("inst_latch", inst_latch, !err);
        tick();
        lsu_rsp_valid = 0; lsu_rsp_err = 0; ifu_rsp_valid = 0; ifu_rsp_err = 0;
        ok = 1;
    endtask

    // Issues one instruction; the expected commit is derived from the architectural rules.
    task automatic applyStimulus(input int kind, input logic rdw, input logic csrw, input logic [31:0] npc,
                                 input int ird, input int irs, input int lrd, input int lrs,
                                 input bit spur, output exp_t eOut);
        exp_t e;
        bit   ok;
        bit   mem;
        int   expLat;
        mem = (kind == K_LOAD) || (kind == K_STORE) || (kind == K_LSERR);
        e.pc = modelPc; e.rf = 0; e.csr = 0; e.ret = 0; e.halt = 1; e.code = 2'd0;
        if (kind == K_EBREAK) e.code = 2'd0;
        else if (kind == K_IFERR) e.code = 2'd1;
        else if (kind == K_LSERR) e.code = 2'd2;
        else if (npc[1:0] != 2'b00) e.code = 2'd3;
        else begin
            e.halt = 0; e.ret = 1; e.rf = rdw && (kind != K_STORE); e.csr = csrw;
            modelPc = npc;
        end
        eOut = e;
        expLat = 4 + ird + irs + (mem ? 2 + lrd + lrs : 0);
        expQ.push_back(e);
        is_load = (kind == K_LOAD) || (kind == K_LSERR);
        is_store = (kind == K_STORE);
        is_ebreak = (kind == K_EBREAK);
        rd_wen_dec = rdw; csr_wen_dec = csrw; dnpc = npc;
        busXfer(0, ird, irs, kind == K_IFERR, spur, e.pc, ok);
        if (ok && mem) busXfer(1, lrd, lrs, kind == K_LSERR, spur, e.pc, ok);
        if (!ok) begin
            expQ.delete();
            return;
        end
        for (int i = 0; i < 12; i++) begin
            if (retire || halted) break;
            tick();
        end
        if (retire) begin
            checkOutput("commit latency", lat, expLat);
            tick();
        end else if (!halted) begin
            checkOutput("completion timeout", 0, 1);
        end
        #2;
        checkOutput("scoreboard drained", expQ.size(), 0);
    endtask

    // After a halt, bus responses must not revive the sequencer.
    task automatic postHaltCheck(input exp_t e);
`ifdef YSYX_25020047_PERF_EN
        logic [63:0] cyc0;
        cyc0 = cycle_cnt;
`endif
        for (int i = 0; i < 3; i++) begin
            ifu_rsp_valid = 1; lsu_rsp_valid = 1;
            #1;
            checkOutput("halt inst_latch", inst_latch, 0);
            tick();
            ifu_rsp_valid = 0; lsu_rsp_valid = 0;
            tick();
            checkOutput("halt sticky", halted, 1);
            checkOutput("halt code held", halt_code, e.code);
            checkOutput("halt pc held", pc, e.pc);
            checkOutput("halt req valids", {ifu_req_valid, lsu_req_valid}, 0);
        end
`ifdef YSYX_25020047_PERF_EN
        checkOutput("cycle_cnt frozen in halt", cycle_cnt, cyc0);
`endif
    endtask

    // Monitor: every commit strobe or halt entry consumes one scoreboard entry.
    initial begin
        logic haltedPrev;
        exp_t e;
        haltedPrev = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                haltedPrev = 0;
            end else begin
                if (retire || rf_wen || csr_wen || (halted && !haltedPrev)) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected commit event", {retire, rf_wen, csr_wen, halted}, 0);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("retire", retire, e.ret);
                        checkOutput("rf_wen", rf_wen, e.rf);
                        checkOutput("csr_wen", csr_wen, e.csr);
                        checkOutput("halted", halted, e.halt);
                        checkOutput("commit pc", pc, e.pc);
                        if (e.halt) checkOutput("halt_code", halt_code, e.code);
                    end
                end
                haltedPrev = halted;
            end
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        exp_t e;
        bit   ok;
        int   n, hk;
        logic [31:0] npc;
`ifdef YSYX_25020047_PERF_EN
        logic [63:0] stall0, ret0;
`endif

        // Directed: addi, lw with slow LSU, sw, csrrw, misaligned jal.
        doReset();
        applyStimulus(K_ALU, 1, 0, RST_PC + 32'd4, 0, 0, 0, 0, 0, e);
        checkOutput("pc after addi", pc, 32'h8000_0004);
`ifdef YSYX_25020047_PERF_EN
        stall0 = mem_stall_cnt; ret0 = instret_cnt;
`endif
        applyStimulus(K_LOAD, 1, 0, modelPc + 32'd4, 0, 0, 3, 0, 0, e);
`ifdef YSYX_25020047_PERF_EN
        checkOutput("mem_stall_cnt lw", mem_stall_cnt - stall0, 5);
        checkOutput("instret_cnt lw", instret_cnt - ret0, 1);
`endif
        applyStimulus(K_STORE, 1, 0, modelPc + 32'd4, 0, 0, 0, 0, 0, e);
        applyStimulus(K_ALU, 1, 1, modelPc + 32'd4, 1, 1, 0, 0, 1, e);
        applyStimulus(K_ALU, 1, 0, 32'h8000_0102, 0, 0, 0, 0, 0, e);
        postHaltCheck(e);

        // Directed: ebreak.
        doReset();
        applyStimulus(K_EBREAK, 0, 0, RST_PC + 32'd4, 0, 0, 0, 0, 0, e);
        postHaltCheck(e);

        // Directed: reset during MWAIT, then a stale LSU response.
        doReset();
        is_load = 1; rd_wen_dec = 1; dnpc = RST_PC + 32'd4;
        busXfer(0, 0, 0, 0, 0, RST_PC, ok);
        tick();
        lsu_req_ready = 1;
        tick();
        lsu_req_ready = 0;
        rst_n = 0;
        #1;
        checkOutput("async reset pc", pc, RST_PC);
        checkOutput("async reset lsu valid", lsu_req_valid, 0);
        tick();
        rst_n = 1;
        lsu_rsp_valid = 1;
        tick();
        lsu_rsp_valid = 0;
        ifu_rsp_valid = 1;
        tick();
        ifu_rsp_valid = 0;
        checkOutput("refetch pc", pc, RST_PC);
        checkOutput("refetch req", ifu_req_valid, 1);
        clearInputs();
        modelPc = RST_PC;
        applyStimulus(K_ALU, 1, 0, RST_PC + 32'd8, 0, 0, 0, 0, 0, e);
        checkOutput("pc after recovery", pc, RST_PC + 32'd8);

        // Random episodes, each ending in a randomly chosen halt cause.
        for (int ep = 0; ep < 6; ep++) begin
            doReset();
            n = $urandom_range(4, 8);
            for (int k = 0; k < n; k++) begin
                npc = modelPc + 32'(4 * $urandom_range(1, 4));
                applyStimulus($urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), npc,
                              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                              $urandom_range(0, 3), 1'($urandom_range(0, 1)), e);
            end
            hk = $urandom_range(0, 3);
            npc = modelPc + 32'($urandom_range(1, 3));
            applyStimulus(hk == 0 ? K_EBREAK : hk == 1 ? K_IFERR : hk == 2 ? K_LSERR : K_ALU,
                          1, 1, npc, $urandom_range(0, 2), $urandom_range(0, 2),
                          $urandom_range(0, 2), $urandom_range(0, 2), 0, e);
            postHaltCheck(e);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
